// File: rtl/mdio_pkg.sv
// Shared types and constants for the Clause-22 MDIO management target.
package mdio_pkg;
    localparam int         MDIO_DATA_W = 16;
    localparam logic [1:0] OP_RD       = 2'b10;
    localparam logic [1:0] OP_WR       = 2'b01;

    typedef enum logic [3:0] {
        IDLE, ST2, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP
    } mdio_state_e;
endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for MDC/MDIO plus a one-clk pulse on MDC rising edge.
module mdio_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdi,
    output logic mdi_s,
    output logic mdc_rise
);
    logic [1:0] mdc_ff;
    logic [1:0] mdi_ff;
    logic       mdc_d;

    // Sync both lines; an undriven (z/x) mdio resolves to 1 as the pull-up would.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_ff <= 2'b00;
            mdi_ff <= 2'b11;
            mdc_d  <= 1'b0;
        end else begin
            mdc_ff <= {mdc_ff[0], mdc};
            mdi_ff <= {mdi_ff[0], (mdi !== 1'b0)};
            mdc_d  <= mdc_ff[1];
        end
    end

    assign mdc_rise = mdc_ff[1] & ~mdc_d;
    assign mdi_s    = mdi_ff[1];
endmodule

// File: rtl/mdio_phy_regs.sv
// Clause-22 MDIO target: frame decoder FSM and 32x16 PHY register bank.
module mdio_phy_regs
    import mdio_pkg::*;
#(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [15:0] PHY_ID1  = 16'h0141,
    parameter logic [15:0] PHY_ID2  = 16'h0CC2,
    parameter int          PRE_MIN  = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdi,
    output logic        mdo,
    output logic        mdo_en,
    output logic        wr_stb,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);
    localparam int PW = $clog2(PRE_MIN + 1);

    logic                   mdi_s, mdc_rise;
    mdio_state_e            state;
    logic [PW-1:0]          pre_cnt;
    logic [4:0]             bit_cnt;
    logic                   op_b0, op_rd;
    logic [4:0]             phyad, regad;
    logic [MDIO_DATA_W-1:0] shreg;
    logic [31:0][MDIO_DATA_W-1:0] bank;

    logic [4:0]             regad_nx;
    logic [MDIO_DATA_W-1:0] wdata_nx;
    assign regad_nx = {regad[3:0], mdi_s};
    assign wdata_nx = {shreg[MDIO_DATA_W-2:0], mdi_s};

    mdio_sync_edge u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdi      (mdi),
        .mdi_s    (mdi_s),
        .mdc_rise (mdc_rise)
    );

    // Frame FSM: everything advances only on the clk cycle of a synced MDC rise.
    // Regs 2/3 hold the ID constants from reset and are never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pre_cnt   <= '0;
            bit_cnt   <= '0;
            op_b0     <= 1'b0;
            op_rd     <= 1'b0;
            phyad     <= '0;
            regad     <= '0;
            shreg     <= '0;
            mdo       <= 1'b0;
            mdo_en    <= 1'b0;
            wr_stb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < 32; i++)
                bank[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : '0;
        end else begin
            wr_stb    <= 1'b0;
            frame_err <= 1'b0;
            if (mdc_rise) begin
                case (state)
                    IDLE: begin
                        if (mdi_s) begin
                            if (pre_cnt < PW'(PRE_MIN)) pre_cnt <= pre_cnt + 1'b1;
                        end else begin
                            if (pre_cnt >= PW'(PRE_MIN)) state <= ST2;
                            pre_cnt <= '0;
                        end
                    end
                    ST2: begin
                        bit_cnt <= '0;
                        if (mdi_s) state <= OP;
                        else begin frame_err <= 1'b1; state <= IDLE; end
                    end
                    OP: begin
                        if (bit_cnt == 5'd0) begin
                            op_b0   <= mdi_s;
                            bit_cnt <= 5'd1;
                        end else if ({op_b0, mdi_s} == OP_RD || {op_b0, mdi_s} == OP_WR) begin
                            op_rd   <= ({op_b0, mdi_s} == OP_RD);
                            bit_cnt <= '0;
                            state   <= PHYAD;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                    PHYAD: begin
                        phyad <= {phyad[3:0], mdi_s};
                        if (bit_cnt == 5'd4) begin bit_cnt <= '0; state <= REGAD; end
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                    REGAD: begin
                        regad <= regad_nx;
                        if (bit_cnt == 5'd4) begin
                            bit_cnt <= '0;
                            if (phyad != PHY_ADDR) state <= SKIP;
                            else begin
                                shreg <= bank[regad_nx];
                                state <= TA;
                            end
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                    SKIP: begin
                        if (bit_cnt == 5'd17) state <= IDLE;
                        else bit_cnt <= bit_cnt + 1'b1;
                    end
                    TA: begin
                        if (op_rd) begin
                            if (bit_cnt == 5'd0) begin
                                // Master released the bus during TA bit1; take it for TA bit2.
                                mdo_en  <= 1'b1;
                                mdo     <= 1'b0;
                                bit_cnt <= 5'd1;
                            end else begin
                                mdo     <= shreg[MDIO_DATA_W-1];
                                shreg   <= {shreg[MDIO_DATA_W-2:0], 1'b0};
                                bit_cnt <= '0;
                                state   <= RDATA;
                            end
                        end else if (bit_cnt == 5'd0) begin
                            if (mdi_s) bit_cnt <= 5'd1;
                            else begin frame_err <= 1'b1; state <= IDLE; end
                        end else begin
                            bit_cnt <= '0;
                            if (!mdi_s) state <= WDATA;
                            else begin frame_err <= 1'b1; state <= IDLE; end
                        end
                    end
                    WDATA: begin
                        shreg <= wdata_nx;
                        if (bit_cnt == 5'd15) begin
                            if (regad != 5'd2 && regad != 5'd3) bank[regad] <= wdata_nx;
                            wr_stb  <= 1'b1;
                            wr_addr <= regad;
                            wr_data <= wdata_nx;
                            state   <= IDLE;
                        end else bit_cnt <= bit_cnt + 1'b1;
                    end
                    RDATA: begin
                        if (bit_cnt == 5'd15) begin
                            mdo_en <= 1'b0;
                            mdo    <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            mdo     <= shreg[MDIO_DATA_W-1];
                            shreg   <= {shreg[MDIO_DATA_W-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
